// File: rtl/multu_pkg.sv
// Shared constants for the unsigned multiply unit and the ALU control stage.
//   DEFAULT_WIDTH : default operand width
//   OP_*          : MULTUOperation encodings recognised by the multiply unit
//   state_t       : multiply unit FSM states
package multu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned OP_W          = 6;

    localparam logic [OP_W-1:0] OP_MULTU = 6'b011001;
    localparam logic [OP_W-1:0] OP_MFHI  = 6'b010000;
    localparam logic [OP_W-1:0] OP_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multu_unit.sv
// Iterative unsigned multiplier with HI/LO registers (one shift-add step per cycle).
// Ports:
//   Clk, Reset_n     : clock, asynchronous active-low reset
//   MULTUOperation   : opcode (MULTU starts, MFHI/MFLO read, others ignored)
//   A, B             : multiplicand, multiplier
//   Result           : registered MFHI/MFLO read data
//   Hi, Lo           : upper/lower halves of the last completed product
//   Busy             : multiply in progress
//   Done             : one-cycle pulse after HI/LO are written
//   Stall            : combinational pipeline hold for unit opcodes issued while busy
module multu_unit
    import multu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [OP_W-1:0]  MULTUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_t             state,  state_nxt;
    logic [WIDTH-1:0]   mcand,  mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [ACC_W-1:0]   acc,    acc_nxt;
    logic [CNT_W-1:0]   cnt,    cnt_nxt;
    logic [WIDTH-1:0]   hi_q,   hi_nxt;
    logic [WIDTH-1:0]   lo_q,   lo_nxt;
    logic [WIDTH-1:0]   res_q,  res_nxt;

    logic               is_multu, is_mfhi, is_mflo;
    logic [WIDTH:0]     sum;
    logic [ACC_W-1:0]   acc_step;
    logic               unused_acc_lsb;

    // Opcode decode
    assign is_multu = (MULTUOperation == OP_MULTU);
    assign is_mfhi  = (MULTUOperation == OP_MFHI);
    assign is_mflo  = (MULTUOperation == OP_MFLO);

    assign Busy   = (state == ST_RUN);
    assign Done   = (state == ST_DONE);
    assign Stall  = (state == ST_RUN) && (is_multu || is_mfhi || is_mflo);
    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign Result = res_q;

    // The accumulator LSB is shifted out on every step and never read
    assign unused_acc_lsb = acc[0];

    // One shift-add step: carry out of the upper-half add becomes the new MSB
    always_comb begin
        sum      = {1'b0, acc[ACC_W-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        res_nxt    = res_q;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (is_multu) begin
                    mcand_nxt  = A;
                    mplier_nxt = B;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_RUN;
                end else if (is_mfhi) begin
                    res_nxt = hi_q;
                end else if (is_mflo) begin
                    res_nxt = lo_q;
                end
            end
            ST_RUN: begin
                acc_nxt    = acc_step;
                mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
                cnt_nxt    = cnt + CNT_W'(1);
                // Last step: commit the finished product straight from the step result
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    hi_nxt    = acc_step[ACC_W-1:WIDTH];
                    lo_nxt    = acc_step[WIDTH-1:0];
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_q  <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            res_q  <= res_nxt;
        end
    end

endmodule

// File: doc/multu_unit.md
MULTU_UNIT -- requirements
Module: multu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; HI and LO are each WIDTH bits.
REQ-002 SHALL have port Clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port MULTUOperation  input  6  operation code from the ALU control stage.
REQ-005 SHALL have port A  input  WIDTH  multiplicand (rs).
REQ-006 SHALL have port B  input  WIDTH  multiplier (rt).
REQ-007 SHALL have port Result  output  WIDTH  registered MFHI/MFLO read data.
REQ-008 SHALL have port Hi  output  WIDTH  HI register contents.
REQ-009 SHALL have port Lo  output  WIDTH  LO register contents.
REQ-010 SHALL have port Busy  output  1  high while the multiply is in progress (state RUN).
REQ-011 SHALL have port Done  output  1  one-cycle pulse, high when HI/LO have just been written.
REQ-012 SHALL have port Stall  output  1  combinational request to hold the pipeline.

Function
REQ-013 SHALL decode MULTUOperation: 011001 = MULTU, 010000 = MFHI, 010010 = MFLO; every other code is a no-op.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; Busy = (state == RUN); Done = (state == DONE).
REQ-015 SHALL, in IDLE or DONE on an edge with MULTU, latch A and B, clear the 2*WIDTH-bit accumulator, clear the iteration counter, and enter RUN.
REQ-016 SHALL, each RUN cycle, perform one unsigned shift-add step: if the multiplier LSB is 1, add the multiplicand to the accumulator upper half with a WIDTH+1-bit sum (carry kept); then shift accumulator and multiplier right by 1.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles; on the WIDTHth RUN edge, write HI = product[2*WIDTH-1:WIDTH], LO = product[WIDTH-1:0], and enter DONE.
REQ-018 SHALL, with WIDTH=32, start at edge E0, write HI/LO at edge E32, hold Done high between E32 and E33, and return to IDLE at E33 unless a new MULTU is present.
REQ-019 SHALL compute the product modulo nothing: the full 2*WIDTH-bit unsigned result with no overflow or truncation.
REQ-020 SHALL, on MFHI (MFLO) in IDLE or DONE, load Result with HI (LO) at that edge; in DONE the newly written value is returned.
REQ-021 SHALL assert Stall = (state == RUN) AND (code is MULTU, MFHI or MFLO); no-op codes never stall.
REQ-022 SHALL ignore MULTU, MFHI and MFLO presented in RUN: operands, HI, LO and Result are unchanged and the multiply in progress continues.
REQ-023 SHALL hold Result, HI and LO unchanged on no-op codes.
REQ-024 SHALL accept MULTU in DONE as a back-to-back start (DONE -> RUN), with HI/LO retaining the previous product until the new one completes.

Reset
REQ-025 SHALL, on Reset_n low at any time, immediately force state IDLE, Busy 0, Done 0, Result 0, Hi 0, Lo 0, and clear the counter, accumulator and operand registers.
REQ-026 SHALL abort a multiply in progress on reset with no partial write to HI/LO; Stall depends only on state and input, so it is 0 during reset.

Structure
REQ-027 SHALL take opcode constants (MULTU, MFHI, MFLO), the FSM state enum and default WIDTH from shared package multu_pkg, which the ALU control unit also uses.
REQ-028 SHALL be a single module with no sub-modules; the counter width SHALL be $clog2(WIDTH)+1.

Verification
REQ-029 SHALL cover: MULTU A=3, B=5 -> Busy for 32 cycles, Done pulse, Hi=0x00000000, Lo=0x0000000F; then MFLO -> Result=0x0000000F.
REQ-030 SHALL cover: MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; MFHI -> Result=0xFFFFFFFE.
REQ-031 SHALL cover: MFHI at RUN cycle 5 -> Stall=1 that cycle, Result unchanged; MULTU at RUN cycle 7 -> Stall=1, operands unchanged.
REQ-032 SHALL cover: Reset_n low at RUN cycle 10 -> Busy=0, Hi=Lo=Result=0 immediately; no Done pulse follows.
REQ-033 SHALL cover: MULTU 2*3, then MULTU 7*0 presented in DONE -> Lo=6 until the second Done, then Hi=0, Lo=0.
REQ-034 SHALL cover: opcodes 000000 and 100000 in IDLE and RUN -> Stall=0, no state, HI, LO or Result change.
